// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the sprite/tile renderers.
// Every signal is flop-driven by the generator; consumers only sample.
interface vga_timing_gen_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    input DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running X/Y counters with registered decodes aligned to the coordinates;
// hs/vs trail by SYNC_DELAY cycles. Free-running, no backpressure.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1
) (
  input  logic             vga_clk,
  input  logic             reset,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  generate
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_total_chk
      $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (SYNC_DELAY < 0 || SYNC_DELAY > 3) begin : g_delay_chk
      $error("vga_timing_gen: SYNC_DELAY must be in 0..3");
    end
  endgenerate

  // Thresholds are 11 bits so a 1024-wide visible region still compares correctly.
  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
  localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
  localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [9:0]  x_q;
  logic [9:0]  y_q;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic [10:0] x_ext;
  logic [10:0] y_ext;
  logic        fs_nxt;
  logic        blank_q;
  logic        ls_q;
  logic        fs_q;
  logic        hs_raw_q;
  logic        vs_raw_q;
  logic [15:0] fc_q;

  always_comb begin
    x_nxt = x_q + 10'd1;
    y_nxt = y_q;
    if (x_q == H_LAST) begin
      x_nxt = '0;
      y_nxt = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
    end
    x_ext  = {1'b0, x_nxt};
    y_ext  = {1'b0, y_nxt};
    fs_nxt = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  // Decodes use the next-state coordinates so they land in the same cycle as DrawX/DrawY.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      x_q      <= H_LAST;
      y_q      <= V_LAST;
      blank_q  <= 1'b0;
      ls_q     <= 1'b0;
      fs_q     <= 1'b0;
      hs_raw_q <= 1'b1;
      vs_raw_q <= 1'b1;
      fc_q     <= 16'hFFFF;
    end else begin
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      blank_q  <= (x_ext < H_VIS) && (y_ext < V_VIS);
      ls_q     <= (x_nxt == 10'd0);
      fs_q     <= fs_nxt;
      hs_raw_q <= !((x_ext >= HS_BEG) && (x_ext < HS_END));
      vs_raw_q <= !((y_ext >= VS_BEG) && (y_ext < VS_END));
      fc_q     <= fs_nxt ? fc_q + 16'd1 : fc_q;
    end
  end

  assign vid.DrawX       = x_q;
  assign vid.DrawY       = y_q;
  assign vid.blank       = blank_q;
  assign vid.line_start  = ls_q;
  assign vid.frame_start = fs_q;
  assign vid.frame_count = fc_q;

  generate
    if (SYNC_DELAY == 0) begin : g_nodly
      assign vid.hs = hs_raw_q;
      assign vid.vs = vs_raw_q;
    end else begin : g_dly
      logic [SYNC_DELAY-1:0] hs_dly;
      logic [SYNC_DELAY-1:0] vs_dly;

      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          hs_dly <= '1;
          vs_dly <= '1;
        end else begin
          hs_dly <= SYNC_DELAY'({hs_dly, hs_raw_q});
          vs_dly <= SYNC_DELAY'({vs_dly, vs_raw_q});
        end
      end

      assign vid.hs = hs_dly[SYNC_DELAY-1];
      assign vid.vs = vs_dly[SYNC_DELAY-1];
    end
  endgenerate

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default timing (no delay), reduced-height frame (delay 1), tiny frame (delay 3).
module tb_vga_timing_gen;
  logic vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  logic rst0, rst1, rst2;
  int n_cmp = 0;
  int n_bad = 0;

  vga_timing_gen_if if0();
  vga_timing_gen_if if1();
  vga_timing_gen_if if2();

  vga_timing_gen #(.SYNC_DELAY(0)) u0 (.vga_clk(vga_clk), .reset(rst0), .vid(if0));
  vga_timing_gen #(.V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3), .SYNC_DELAY(1))
    u1 (.vga_clk(vga_clk), .reset(rst1), .vid(if1));
  vga_timing_gen #(.H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
                   .V_VISIBLE(2), .V_FRONT(1), .V_SYNC(1), .V_BACK(1), .SYNC_DELAY(3))
    u2 (.vga_clk(vga_clk), .reset(rst2), .vid(if2));

  // Packed view: {DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count}
  task automatic test_reset();
    logic [40:0] got, exp;
    n_cmp++; if (if0.DrawX !== 10'd799) begin n_bad++; $display("FAIL rst_drawx: got %0d want 799", if0.DrawX); end
    n_cmp++; if (if0.DrawY !== 10'd524) begin n_bad++; $display("FAIL rst_drawy: got %0d want 524", if0.DrawY); end
    n_cmp++; if ({if0.blank, if0.line_start, if0.frame_start} !== 3'b000) begin
      n_bad++; $display("FAIL rst_flags: got %b want 000", {if0.blank, if0.line_start, if0.frame_start}); end
    n_cmp++; if ({if0.hs, if0.vs} !== 2'b11) begin n_bad++; $display("FAIL rst_sync: got %b want 11", {if0.hs, if0.vs}); end
    n_cmp++; if (if0.frame_count !== 16'hFFFF) begin n_bad++; $display("FAIL rst_fc: got %h want ffff", if0.frame_count); end
    got = {if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs, if1.line_start, if1.frame_start, if1.frame_count};
    exp = {10'd799, 10'd14, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_u1: got %h want %h", got, exp); end
    got = {if2.DrawX, if2.DrawY, if2.blank, if2.hs, if2.vs, if2.line_start, if2.frame_start, if2.frame_count};
    exp = {10'd6, 10'd4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFF};
    n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL rst_u2: got %h want %h", got, exp); end
  endtask

  task automatic test_release();
    @(negedge vga_clk); rst0 = 1'b0;
    @(negedge vga_clk);
    n_cmp++; if ({if0.DrawX, if0.DrawY} !== {10'd0, 10'd0}) begin
      n_bad++; $display("FAIL rel_xy: got (%0d,%0d) want (0,0)", if0.DrawX, if0.DrawY); end
    n_cmp++; if ({if0.blank, if0.line_start, if0.frame_start} !== 3'b111) begin
      n_bad++; $display("FAIL rel_flags: got %b want 111", {if0.blank, if0.line_start, if0.frame_start}); end
    n_cmp++; if (if0.frame_count !== 16'h0000) begin n_bad++; $display("FAIL rel_fc_wrap: got %h want 0000", if0.frame_count); end
    @(negedge vga_clk);
    n_cmp++; if ({if0.DrawX, if0.DrawY, if0.line_start, if0.frame_start} !== {10'd1, 10'd0, 2'b00}) begin
      n_bad++; $display("FAIL rel_second: got (%0d,%0d) ls=%b fs=%b want (1,0) ls=0 fs=0",
                        if0.DrawX, if0.DrawY, if0.line_start, if0.frame_start); end
  endtask

  // Line 5 of the default raster, no sync delay.
  task automatic test_hdecode();
    logic [24:0] got, exp;
    int hs_low = 0;
    repeat (3999) @(negedge vga_clk);
    for (int x = 0; x < 800; x++) begin
      got = {if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs, if0.line_start, if0.frame_start};
      exp = {10'(x), 10'd5, (x < 640), !(x >= 656 && x < 752), 1'b1, (x == 0), 1'b0};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL hline x=%0d: got %h want %h", x, got, exp); end
      if (if0.hs === 1'b0) hs_low++;
      @(negedge vga_clk);
    end
    n_cmp++; if (hs_low != 96) begin n_bad++; $display("FAIL hs_width: got %0d want 96", hs_low); end
    n_cmp++; if ({if0.DrawX, if0.DrawY, if0.line_start} !== {10'd0, 10'd6, 1'b1}) begin
      n_bad++; $display("FAIL hwrap: got (%0d,%0d) ls=%b want (0,6) ls=1", if0.DrawX, if0.DrawY, if0.line_start); end
  endtask

  task automatic test_async_reset();
    repeat (300) @(negedge vga_clk);
    n_cmp++; if ({if0.DrawX, if0.DrawY} !== {10'd300, 10'd6}) begin
      n_bad++; $display("FAIL arst_pre: got (%0d,%0d) want (300,6)", if0.DrawX, if0.DrawY); end
    #2 rst0 = 1'b1;
    #1;
    n_cmp++; if ({if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs, if0.line_start, if0.frame_start, if0.frame_count}
                 !== {10'd799, 10'd524, 5'b01100, 16'hFFFF}) begin
      n_bad++; $display("FAIL arst_now: got (%0d,%0d) b=%b hs=%b vs=%b fc=%h want (799,524) b=0 hs=1 vs=1 fc=ffff",
                        if0.DrawX, if0.DrawY, if0.blank, if0.hs, if0.vs, if0.frame_count); end
    @(negedge vga_clk); @(negedge vga_clk); rst0 = 1'b0;
    @(negedge vga_clk);
    n_cmp++; if ({if0.DrawX, if0.DrawY, if0.blank, if0.line_start, if0.frame_start, if0.frame_count}
                 !== {10'd0, 10'd0, 3'b111, 16'h0000}) begin
      n_bad++; $display("FAIL arst_restart: got (%0d,%0d) flags=%b fc=%h want (0,0) flags=111 fc=0000",
                        if0.DrawX, if0.DrawY, {if0.blank, if0.line_start, if0.frame_start}, if0.frame_count); end
  endtask

  // Default width, 15-line frame (8/2/2/3), hs/vs one cycle late; full frame plus one cycle.
  task automatic test_sync_delay();
    logic [40:0] got, exp;
    int vs_low = 0, blank_hi = 0, fs_cnt = 0;
    int ex, ey, qx, qy;
    logic hs_e, vs_e;
    @(negedge vga_clk); rst1 = 1'b0;
    for (int p = 0; p <= 12000; p++) begin
      @(negedge vga_clk);
      ex = p % 800; ey = (p / 800) % 15;
      qx = (p - 1) % 800; qy = ((p - 1) / 800) % 15;
      hs_e = (p == 0) ? 1'b1 : !(qx >= 656 && qx < 752);
      vs_e = (p == 0) ? 1'b1 : !(qy >= 10 && qy < 12);
      got = {if1.DrawX, if1.DrawY, if1.blank, if1.hs, if1.vs, if1.line_start, if1.frame_start, if1.frame_count};
      exp = {10'(ex), 10'(ey), (ex < 640 && ey < 8), hs_e, vs_e, (ex == 0), (p % 12000 == 0), 16'(p / 12000)};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL dly p=%0d: got %h want %h", p, got, exp); end
      if (if1.vs === 1'b0) vs_low++;
      if (p < 12000 && if1.blank === 1'b1) blank_hi++;
      if (if1.frame_start === 1'b1) fs_cnt++;
    end
    n_cmp++; if (vs_low != 1600) begin n_bad++; $display("FAIL vs_width: got %0d want 1600", vs_low); end
    n_cmp++; if (blank_hi != 5120) begin n_bad++; $display("FAIL blank_count: got %0d want 5120", blank_hi); end
    n_cmp++; if (fs_cnt != 2) begin n_bad++; $display("FAIL fs_count_u1: got %0d want 2", fs_cnt); end
  endtask

  // 7x5 raster, three-stage sync delay, five frame starts 35 cycles apart.
  task automatic test_small();
    logic [40:0] got, exp;
    int last_fs = -1, fs_cnt = 0;
    int ex, ey, q;
    logic hs_e, vs_e;
    @(negedge vga_clk); rst2 = 1'b0;
    for (int p = 0; p <= 140; p++) begin
      @(negedge vga_clk);
      ex = p % 7; ey = (p / 7) % 5; q = p - 3;
      hs_e = (q < 0) ? 1'b1 : ((q % 7) != 5);
      vs_e = (q < 0) ? 1'b1 : (((q / 7) % 5) != 3);
      got = {if2.DrawX, if2.DrawY, if2.blank, if2.hs, if2.vs, if2.line_start, if2.frame_start, if2.frame_count};
      exp = {10'(ex), 10'(ey), (ex < 4 && ey < 2), hs_e, vs_e, (ex == 0), (p % 35 == 0), 16'(p / 35)};
      n_cmp++; if (got !== exp) begin n_bad++; $display("FAIL small p=%0d: got %h want %h", p, got, exp); end
      if (if2.frame_start === 1'b1) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          n_cmp++; if (p - last_fs != 35) begin n_bad++; $display("FAIL fs_spacing: got %0d want 35", p - last_fs); end
        end
        last_fs = p;
      end
    end
    n_cmp++; if (fs_cnt != 5) begin n_bad++; $display("FAIL fs_count_u2: got %0d want 5", fs_cnt); end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    #1;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    #2;
    test_reset();
    test_release();
    test_hdecode();
    test_async_reset();
    test_sync_delay();
    test_small();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
